spi_frame_assembler: RTL and testbench
======================================

# spi_frame_assembler

Sits directly downstream of the SPI byte receiver (SpiBuffer) and turns its free-running byte output into framed packets for the system clock domain. It synchronises the receiver's byte-changed strobe and chip select into `clock`, captures each received byte, delimits frames by chip-select deassertion, and buffers framed bytes in a FIFO. The FIFO drains through an Avalon-ST source with start/end-of-packet markers.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, at least 4.
- `MAX_FRAME`, 64: maximum bytes per frame; any further bytes are dropped.
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `io_InputBuffer`  in  8  received byte from SpiBuffer; asynchronous to `clock`; stable for at least 8 SCK periods after a change.
- `io_BufferChanged`  in  1  byte-complete strobe from SpiBuffer; asynchronous to `clock`.
- `io_ChipSelect`  in  1  SPI CS, active-low; asynchronous to `clock`.
- `io_Out_valid`  out  1  Avalon-ST valid.
- `io_Out_ready`  in  1  Avalon-ST ready (readyLatency 0).
- `io_Out_data`  out  8  byte.
- `io_Out_startofpacket`  out  1  first byte of a frame.
- `io_Out_endofpacket`  out  1  last byte of a frame.
- `io_Overflow`  out  1  sticky: a byte was dropped because the FIFO was full.
- `io_FrameTooLong`  out  1  sticky: a frame exceeded `MAX_FRAME`.
- `io_ClearFlags`  in  1  synchronous clear of both sticky flags.
- `io_Level`  out  log2(DEPTH)+1  current FIFO occupancy.

## Operation
- Synchronisation: `io_BufferChanged` and `io_ChipSelect` each pass through a 2-flop synchroniser. The byte event is the rising edge of synced Changed. The end event is the rising edge of synced CS.
- On a byte event, `io_InputBuffer` is sampled directly; it is stable by then.
- Staging register holds `{data, sop}` plus a staged-valid bit. A frame counter tracks bytes in the current frame.
- On a byte event:
  - If the frame counter is below `MAX_FRAME`: push any staged byte with eop=0, then stage the new byte. Its sop is 1 when the counter is 0. Increment the counter.
  - Otherwise: drop the byte and set `io_FrameTooLong`.
- On an end event: push any staged byte with eop=1, clear staged-valid, and reset the counter to 0. If nothing is staged (CS pulse with no bytes), push nothing.
- Byte event and end event in the same cycle: the byte is handled as above, and the end is recorded in a pending-end bit that executes the following cycle.
- A push into a full FIFO drops the entry and sets `io_Overflow`. The staging logic proceeds as if the push succeeded.
- `io_ClearFlags` clears both sticky flags. When a clear coincides with a new set, the set wins.
- Output: `io_Out_valid` = FIFO not empty. Data, sop and eop come from the head entry. The head is popped when valid && ready.
- Push and pop in the same cycle while full: the push is accepted. Occupancy stays unchanged and no overflow is flagged.
- Pointers wrap modulo `DEPTH`. Full and empty are distinguished by an extra pointer bit.

## Timing
- Reset, asserted at any time: all outputs 0, FIFO empty, staging invalid, counter 0, synchronisers cleared to 0, pending-end cleared. A frame in progress is discarded. After release, the frame counter restarts at 0 on the next byte.
- Byte event timing: 3 `clock` cycles after the `io_BufferChanged` rising edge (2 synchroniser cycles plus 1 edge-detect cycle). Staging updates on that edge.
- A staged byte is written to the FIFO in the cycle of the next byte or end event.
- `io_Out_valid` rises 1 cycle after the write into an empty FIFO. The FIFO output is registered, show-ahead.
- End-of-frame latency: last byte visible with eop 4 cycles after the `io_ChipSelect` rising edge (end event at 3, plus 1 cycle FIFO write-to-read).
- Throughput: 1 pop per cycle while ready stays high.
- `io_Level` updates the cycle after a push or pop.

## Structure
- Package `spi_frame_pkg`:
  - typedef `frame_entry_t` {data[7:0], sop, eop};
  - constant `SYNC_STAGES` = 2;
  - `level_width(DEPTH)` function.
- Sub-module `spi_frame_fifo`: DEPTH-entry synchronous FIFO of `frame_entry_t`, registered show-ahead output, full/empty/level outputs.
- Synchronisers and edge detectors stay inline in the top module.

## Test plan
- Single frame: CS low, bytes 0x7A, 0x80, CS high. Output is 0x7A with sop=1, eop=0, then 0x80 with sop=0, eop=1. `io_Level` returns to 0.
- Back-to-back frames {0x0C, 0x40} and {0x55}, ready held low, then raised. Three beats come out in order: 0x0C with sop, 0x40 with eop, then 0x55 with both sop and eop.
- Overflow: `DEPTH`=4, ready low, one 6-byte frame. Only 4 entries are stored (the first 4 bytes), `io_Overflow`=1. Pulsing `io_ClearFlags` returns it to 0.
- `MAX_FRAME`=3, 5-byte frame. Output is 3 beats, with eop on the third byte. `io_FrameTooLong`=1.
- Empty CS pulse (CS high→low→high, no bytes): no output beat. Next frame's first byte carries sop=1.
- Reset asserted mid-frame, after 2 bytes staged and pushed: outputs go to 0 immediately. After release, a new frame {0xA5} emits one beat with sop=1, eop=1.

Source files
------------

// File: rtl/spi_frame_assembler_pkg.sv
// Shared types and helpers for the SPI frame assembler slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// frame_entry_t : one buffered byte plus its packet markers.
// SYNC_STAGES   : depth of the CDC synchronisers on Changed and CS.
// level_width() : bit width needed to hold an occupancy of 0..depth.
package spi_frame_pkg;

   localparam int SYNC_STAGES = 2;

   typedef struct packed {
      logic [7:0] data;
      logic       sop;
      logic       eop;
   } frame_entry_t;

   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/spi_frame_assembler_if.sv
// Avalon-ST byte stream with start/end-of-packet markers.
// Latency: n/a (wiring only).
// Backpressure: ready with readyLatency 0; a beat transfers when valid && ready.
//
// master: drives valid/data/startofpacket/endofpacket, samples ready.
// slave : the reverse.
interface spi_frame_assembler_if;

   logic       valid;
   logic       ready;
   logic [7:0] data;
   logic       startofpacket;
   logic       endofpacket;

   modport master (
      output valid,
      output data,
      output startofpacket,
      output endofpacket,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      input  startofpacket,
      input  endofpacket,
      output ready
   );

endinterface

// File: rtl/spi_frame_assembler_fifo.sv
// DEPTH-entry synchronous FIFO of frame_entry_t with a registered show-ahead head.
// Latency: an entry written into an empty FIFO is visible on out_vld one cycle later.
// Backpressure: pop is honoured only while out_vld; a push while full is ignored unless a pop lands the same cycle.
//
// Ports: clock/reset, push/push_dat (write side), pop (read strobe),
//        out_vld/out_dat (registered head), full/empty/level (occupancy).
module spi_frame_fifo
   import spi_frame_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          push,
   input  frame_entry_t                  push_dat,
   input  logic                          pop,
   output logic                          out_vld,
   output frame_entry_t                  out_dat,
   output logic                          full,
   output logic                          empty,
   output logic [level_width(DEPTH)-1:0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = level_width(DEPTH);

   // One extra pointer bit separates full from empty.
   typedef logic [AW:0] ptr_t;

   ptr_t         wr_ptr;
   ptr_t         rd_ptr;
   ptr_t         rd_ptr_nxt;
   frame_entry_t mem [DEPTH];
   logic         pop_eff;
   logic         wr_en;

   assign level      = wr_ptr - rd_ptr;
   assign full       = (level == LW'(DEPTH));
   assign empty      = (wr_ptr == rd_ptr);
   assign pop_eff    = pop & out_vld;
   // A pop in the same cycle frees the slot the push lands in.
   assign wr_en      = push & (~full | pop_eff);
   assign rd_ptr_nxt = rd_ptr + ptr_t'(pop_eff);

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_ptr[AW-1:0]] <= push_dat;
      end
   end

   // The head register is loaded from entries written before this edge only
   // (pre-update wr_ptr), which gives the one-cycle write-to-visible delay and
   // means the head slot is never the one being written.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         out_vld <= 1'b0;
         out_dat <= '0;
      end else begin
         wr_ptr  <= wr_ptr + ptr_t'(wr_en);
         rd_ptr  <= rd_ptr_nxt;
         out_vld <= (wr_ptr != rd_ptr_nxt);
         out_dat <= (wr_ptr != rd_ptr_nxt) ? mem[rd_ptr_nxt[AW-1:0]] : '0;
      end
   end

endmodule

// File: rtl/spi_frame_assembler.sv
// Turns SpiBuffer's free-running byte output into framed Avalon-ST packets in the clock domain.
// Latency: byte staged 3 cycles after Changed rises; last byte shows with eop 4 cycles after CS rises.
// Backpressure: io_Out.ready stalls the FIFO; bytes arriving into a full FIFO are dropped and flagged.
//
// Ports: clock/reset (async active-low); io_InputBuffer/io_BufferChanged/io_ChipSelect from the
//        SPI receiver (asynchronous); io_Out Avalon-ST source; io_Overflow/io_FrameTooLong sticky
//        flags cleared by io_ClearFlags; io_Level FIFO occupancy.
module spi_frame_assembler
   import spi_frame_pkg::*;
#(
   parameter int DEPTH     = 16,
   parameter int MAX_FRAME = 64
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [7:0]                    io_InputBuffer,
   input  logic                          io_BufferChanged,
   input  logic                          io_ChipSelect,
   spi_frame_assembler_if.master         io_Out,
   output logic                          io_Overflow,
   output logic                          io_FrameTooLong,
   input  logic                          io_ClearFlags,
   output logic [level_width(DEPTH)-1:0] io_Level
);

   localparam int CNT_W = $clog2(MAX_FRAME + 1);

   logic [SYNC_STAGES-1:0] chg_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic                   chg_prev;
   logic                   cs_prev;
   logic                   byte_evt;
   logic                   end_evt;
   logic                   end_now;

   logic                   stg_vld;
   logic                   stg_sop;
   logic [7:0]             stg_dat;
   logic [CNT_W-1:0]       frame_cnt;
   logic                   pend_end;
   logic                   room;

   logic                   fifo_push;
   frame_entry_t           fifo_push_dat;
   logic                   fifo_drop;
   logic                   fifo_vld;
   frame_entry_t           fifo_out;
   logic                   fifo_full;
   logic                   fifo_empty;

   // ---------------- synchronisers and edge detect ----------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         chg_sync <= '0;
         cs_sync  <= '0;
         chg_prev <= 1'b0;
         cs_prev  <= 1'b0;
      end else begin
         chg_sync <= {chg_sync[SYNC_STAGES-2:0], io_BufferChanged};
         cs_sync  <= {cs_sync[SYNC_STAGES-2:0], io_ChipSelect};
         chg_prev <= chg_sync[SYNC_STAGES-1];
         cs_prev  <= cs_sync[SYNC_STAGES-1];
      end
   end

   assign byte_evt = chg_sync[SYNC_STAGES-1] & ~chg_prev;
   assign end_evt  = cs_sync[SYNC_STAGES-1] & ~cs_prev;
   // A byte always wins the cycle; a coincident end waits one cycle in pend_end.
   assign end_now  = ~byte_evt & (pend_end | end_evt);
   assign room     = (frame_cnt < CNT_W'(MAX_FRAME));

   // ---------------- FIFO write decision ----------------
   always_comb begin
      fifo_push     = 1'b0;
      fifo_push_dat = '{data: stg_dat, sop: stg_sop, eop: end_now};
      if (byte_evt) begin
         fifo_push = stg_vld & room;
      end else if (end_now) begin
         fifo_push = stg_vld;
      end
   end

   // Staging carries on as if every push landed; only the flag records the loss.
   assign fifo_drop = fifo_push & fifo_full & ~(fifo_vld & io_Out.ready);

   // ---------------- staging register and frame counter ----------------
   // The input byte is sampled straight from the async bus: by the time the
   // synchronised strobe arrives it has been stable for many SCK periods.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stg_vld   <= 1'b0;
         stg_sop   <= 1'b0;
         stg_dat   <= '0;
         frame_cnt <= '0;
         pend_end  <= 1'b0;
      end else if (byte_evt) begin
         if (room) begin
            stg_vld   <= 1'b1;
            stg_dat   <= io_InputBuffer;
            stg_sop   <= (frame_cnt == '0);
            frame_cnt <= frame_cnt + 1'b1;
         end
         pend_end <= pend_end | end_evt;
      end else if (end_now) begin
         stg_vld   <= 1'b0;
         frame_cnt <= '0;
         pend_end  <= 1'b0;
      end
   end

   // ---------------- sticky flags (set beats clear) ----------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         io_Overflow     <= 1'b0;
         io_FrameTooLong <= 1'b0;
      end else begin
         if (fifo_drop) begin
            io_Overflow <= 1'b1;
         end else if (io_ClearFlags) begin
            io_Overflow <= 1'b0;
         end
         if (byte_evt && !room) begin
            io_FrameTooLong <= 1'b1;
         end else if (io_ClearFlags) begin
            io_FrameTooLong <= 1'b0;
         end
      end
   end

   // ---------------- output FIFO ----------------
   spi_frame_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .push     (fifo_push),
      .push_dat (fifo_push_dat),
      .pop      (io_Out.ready),
      .out_vld  (fifo_vld),
      .out_dat  (fifo_out),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .level    (io_Level)
   );

   // The registered head never claims valid over an empty store.
   assign io_Out.valid         = fifo_vld & ~fifo_empty;
   assign io_Out.data          = fifo_out.data;
   assign io_Out.startofpacket = fifo_out.sop;
   assign io_Out.endofpacket   = fifo_out.eop;

endmodule

// File: tb/tb_spi_frame_assembler.sv
// Bench for spi_frame_assembler: two instances share the SPI stimulus,
// u_main (DEPTH=4, MAX_FRAME=64) and u_max (DEPTH=16, MAX_FRAME=3).
// Expected beats come from frame-level rules: first min(n,MAX) bytes, sop on first, eop on last.
module tb_spi_frame_assembler;
   import spi_frame_pkg::*;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic       reset     = 1'b0;
   logic [7:0] in_buf    = 8'h00;
   logic       chg       = 1'b0;
   logic       cs        = 1'b1;
   logic       clr       = 1'b0;
   logic       rdy_force = 1'b0;
   logic       rnd_mode  = 1'b0;
   logic       rnd_rdy   = 1'b1;
   logic       rdy;

   logic                          ovf_main, tl_main, ovf_max, tl_max;
   logic [level_width(4)-1:0]     lvl_main;
   logic [level_width(16)-1:0]    lvl_max;

   spi_frame_assembler_if out_main ();
   spi_frame_assembler_if out_max ();

   assign rdy            = rnd_mode ? rnd_rdy : rdy_force;
   assign out_main.ready = rdy;
   assign out_max.ready  = rdy;

   spi_frame_assembler #(.DEPTH(4), .MAX_FRAME(64)) u_main (
      .clock            (clock),
      .reset            (reset),
      .io_InputBuffer   (in_buf),
      .io_BufferChanged (chg),
      .io_ChipSelect    (cs),
      .io_Out           (out_main),
      .io_Overflow      (ovf_main),
      .io_FrameTooLong  (tl_main),
      .io_ClearFlags    (clr),
      .io_Level         (lvl_main)
   );

   spi_frame_assembler #(.DEPTH(16), .MAX_FRAME(3)) u_max (
      .clock            (clock),
      .reset            (reset),
      .io_InputBuffer   (in_buf),
      .io_BufferChanged (chg),
      .io_ChipSelect    (cs),
      .io_Out           (out_max),
      .io_Overflow      (ovf_max),
      .io_FrameTooLong  (tl_max),
      .io_ClearFlags    (clr),
      .io_Level         (lvl_max)
   );

   always @(posedge clock) begin
      #1;
      rnd_rdy = ($urandom_range(0, 3) != 0);
   end

   // Beats captured as {data, sop, eop}.
   logic [9:0] q_main [$];
   logic [9:0] q_max [$];
   logic [9:0] exp_main [$];
   logic [9:0] exp_max [$];

   always @(negedge clock) begin
      if (out_main.valid && rdy)
         q_main.push_back({out_main.data, out_main.startofpacket, out_main.endofpacket});
      if (out_max.valid && rdy)
         q_max.push_back({out_max.data, out_max.startofpacket, out_max.endofpacket});
   end

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] fb [8];

   typedef struct packed {
      logic [2:0]  n;
      logic [47:0] b;          // byte i at b[8*i +: 8]
      logic [2:0]  beats_main;
      logic [2:0]  beats_max;
      logic [7:0]  last_max;
      logic        tl_max;
   } vec_t;

   vec_t tbl [6];

   function automatic logic [9:0] mk(input logic [7:0] d, input logic s, input logic e);
      return {d, s, e};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int k);
      repeat (k) @(posedge clock);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      in_buf = b;
      tick(2);
      chg = 1'b1;
      tick(4);
      chg = 1'b0;
      tick(4);
   endtask

   task automatic send_frame(input int n);
      cs = 1'b0;
      tick(4);
      for (int i = 0; i < n; i++) send_byte(fb[i]);
      cs = 1'b1;
      tick(6);
   endtask

   task automatic pulse_clear();
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      tick(1);
   endtask

   task automatic model(input int n, input bit do_main);
      int k;
      if (do_main)
         for (int i = 0; i < n; i++) exp_main.push_back(mk(fb[i], i == 0, i == n - 1));
      k = (n < 3) ? n : 3;
      for (int i = 0; i < k; i++) exp_max.push_back(mk(fb[i], i == 0, i == k - 1));
   endtask

   task automatic flush();
      q_main.delete();
      q_max.delete();
      exp_main.delete();
      exp_max.delete();
   endtask

   task automatic check_frames(input string nm);
      chk({nm, "_count_main"}, 32'(q_main.size()), 32'(exp_main.size()));
      for (int i = 0; i < q_main.size() && i < exp_main.size(); i++)
         chk({nm, "_beat_main"}, 32'(q_main[i]), 32'(exp_main[i]));
      chk({nm, "_count_max"}, 32'(q_max.size()), 32'(exp_max.size()));
      for (int i = 0; i < q_max.size() && i < exp_max.size(); i++)
         chk({nm, "_beat_max"}, 32'(q_max[i]), 32'(exp_max[i]));
      flush();
   endtask

   initial begin
      tbl[0] = '{3'd1, 48'h0000_0000_00A1, 3'd1, 3'd1, 8'hA1, 1'b0};
      tbl[1] = '{3'd2, 48'h0000_0000_B2B1, 3'd2, 3'd2, 8'hB2, 1'b0};
      tbl[2] = '{3'd3, 48'h0000_00C3_C2C1, 3'd3, 3'd3, 8'hC3, 1'b0};
      tbl[3] = '{3'd4, 48'h0000_D4D3_D2D1, 3'd4, 3'd3, 8'hD3, 1'b1};
      tbl[4] = '{3'd5, 48'h00E5_E4E3_E2E1, 3'd5, 3'd3, 8'hE3, 1'b1};
      tbl[5] = '{3'd0, 48'h0000_0000_0000, 3'd0, 3'd0, 8'h00, 1'b0};

      // ---- reset state ----
      tick(3);
      chk("rst_valid", 32'(out_main.valid), 32'd0);
      chk("rst_data", 32'(out_main.data), 32'd0);
      chk("rst_sop", 32'(out_main.startofpacket), 32'd0);
      chk("rst_eop", 32'(out_main.endofpacket), 32'd0);
      chk("rst_ovf", 32'(ovf_main), 32'd0);
      chk("rst_toolong", 32'(tl_main), 32'd0);
      chk("rst_level", 32'(lvl_main), 32'd0);
      reset = 1'b1;
      tick(6);

      // ---- single frame with end-of-frame latency ----
      rdy_force = 1'b1;
      cs = 1'b0;
      tick(4);
      send_byte(8'h7A);
      send_byte(8'h80);
      fb[0] = 8'h7A;
      fb[1] = 8'h80;
      model(2, 1'b1);
      cs = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("eop_lat3_valid", 32'(out_main.valid), 32'd0);
      chk("eop_lat3_level", 32'(lvl_main), 32'd1);
      @(posedge clock);
      @(negedge clock);
      chk("eop_lat4_valid", 32'(out_main.valid), 32'd1);
      chk("eop_lat4_data", 32'(out_main.data), 32'h80);
      chk("eop_lat4_eop", 32'(out_main.endofpacket), 32'd1);
      chk("eop_lat4_sop", 32'(out_main.startofpacket), 32'd0);
      tick(6);
      check_frames("single");
      chk("single_level_idle", 32'(lvl_main), 32'd0);

      // ---- back-to-back frames held off by ready ----
      rdy_force = 1'b0;
      fb[0] = 8'h0C;
      fb[1] = 8'h40;
      model(2, 1'b1);
      send_frame(2);
      fb[0] = 8'h55;
      model(1, 1'b1);
      send_frame(1);
      chk("b2b_level", 32'(lvl_main), 32'd3);
      chk("b2b_head", 32'({out_main.data, out_main.startofpacket}), 32'({8'h0C, 1'b1}));
      rdy_force = 1'b1;
      tick(8);
      check_frames("b2b");
      chk("b2b_level_idle", 32'(lvl_main), 32'd0);

      // ---- overflow (u_main) and too-long frame (u_max) ----
      rdy_force = 1'b0;
      for (int i = 0; i < 6; i++) fb[i] = 8'h11 + 8'(i);
      send_frame(6);
      chk("ovf_flag", 32'(ovf_main), 32'd1);
      chk("ovf_level", 32'(lvl_main), 32'd4);
      chk("toolong_flag", 32'(tl_max), 32'd1);
      chk("toolong_no_ovf", 32'(ovf_max), 32'd0);
      chk("toolong_level", 32'(lvl_max), 32'd3);
      for (int i = 0; i < 4; i++) exp_main.push_back(mk(fb[i], i == 0, 1'b0));
      model(6, 1'b0);
      rdy_force = 1'b1;
      tick(10);
      check_frames("ovf");
      pulse_clear();
      chk("ovf_cleared", 32'(ovf_main), 32'd0);
      chk("toolong_cleared", 32'(tl_max), 32'd0);

      // ---- empty CS pulse, then a one-byte frame ----
      send_frame(0);
      check_frames("empty_cs");
      fb[0] = 8'h3C;
      model(1, 1'b1);
      send_frame(1);
      tick(4);
      check_frames("after_empty");

      // ---- reset mid-frame ----
      rdy_force = 1'b0;
      cs = 1'b0;
      tick(4);
      send_byte(8'h21);
      send_byte(8'h22);
      chk("midrst_pre_valid", 32'(out_main.valid), 32'd1);
      reset = 1'b0;
      #1;
      chk("midrst_valid", 32'(out_main.valid), 32'd0);
      chk("midrst_data", 32'(out_main.data), 32'd0);
      chk("midrst_level", 32'(lvl_main), 32'd0);
      chk("midrst_sop", 32'(out_main.startofpacket), 32'd0);
      cs = 1'b1;
      tick(3);
      reset = 1'b1;
      tick(6);
      flush();
      rdy_force = 1'b1;
      fb[0] = 8'hA5;
      model(1, 1'b1);
      send_frame(1);
      tick(4);
      check_frames("midrst_after");

      // ---- vector table ----
      for (int v = 0; v < 6; v++) begin
         for (int i = 0; i < 6; i++) fb[i] = tbl[v].b[8*i +: 8];
         pulse_clear();
         send_frame(int'(tbl[v].n));
         tick(4);
         chk("tbl_beats_main", 32'(q_main.size()), 32'(tbl[v].beats_main));
         chk("tbl_beats_max", 32'(q_max.size()), 32'(tbl[v].beats_max));
         if (q_max.size() > 0 && tbl[v].beats_max != 0) begin
            chk("tbl_last_max", 32'(q_max[q_max.size()-1]), 32'(mk(tbl[v].last_max, tbl[v].beats_max == 1, 1'b1)));
         end
         chk("tbl_toolong", 32'(tl_max), 32'(tbl[v].tl_max));
         flush();
      end

      // ---- randomized frames against the frame-level model ----
      for (int f = 0; f < 30; f++) begin
         int n;
         n = $urandom_range(0, 6);
         for (int i = 0; i < 8; i++) fb[i] = 8'($urandom);
         pulse_clear();
         model(n, 1'b1);
         rnd_mode = 1'b1;
         send_frame(n);
         rnd_mode = 1'b0;
         rdy_force = 1'b1;
         tick(8);
         chk("rnd_toolong_max", 32'(tl_max), 32'(n > 3));
         chk("rnd_toolong_main", 32'(tl_main), 32'd0);
         chk("rnd_ovf_main", 32'(ovf_main), 32'd0);
         chk("rnd_level_main", 32'(lvl_main), 32'd0);
         check_frames("rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
